// File: rtl/event_flag_reader_if.sv
// Bundle of event inputs, interrupt output and the snapshot read port
// of the sticky event flag bank.
//
// Read handshake: while rd_valid is high, rd_data/rd_ovf hold a stable
// snapshot. The consumer accepts that snapshot by raising rd_ack in any
// cycle where rd_valid is high. The transfer completes on that clock edge.
// rd_ack has no effect while rd_valid is low. rd_req is a level request,
// and it is only looked at while the reader is idle.
interface event_flag_reader_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] ev;
   logic             irq;
   logic             rd_req;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] rd_ovf;
   logic             rd_ack;

   // Event sources and the status consumer.
   modport master (
      output ev, rd_req, rd_ack,
      input  irq, rd_valid, rd_data, rd_ovf
   );

   // The flag bank itself.
   modport slave (
      input  ev, rd_req, rd_ack,
      output irq, rd_valid, rd_data, rd_ovf
   );
endinterface

// File: rtl/event_flag_reader.sv
// Sticky event flag bank with a snapshot / acknowledge read port.
// Producers pulse ev[i]. A flag stays set until a snapshot that contained it
// is acknowledged. Only snapshotted bits are cleared, so an event that
// arrives while a snapshot is presented survives the acknowledge.
// A new event always wins over a clear.
module event_flag_reader #(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] POR_VALUE = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst,
   event_flag_reader_if.slave    bus,
   output logic [1:0]            dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] flags_q, flags_d;
   logic [WIDTH-1:0] ovf_q, ovf_d;
   logic [WIDTH-1:0] snap_data_q, snap_data_d;
   logic [WIDTH-1:0] snap_ovf_q, snap_ovf_d;

   logic             ack_take;
   logic [WIDTH-1:0] clr_flags;
   logic [WIDTH-1:0] clr_ovf;

   // Acknowledge only counts while a snapshot is presented.
   always_comb begin
      ack_take  = (state_q == ST_PRESENT) && bus.rd_ack;
      clr_flags = {WIDTH{ack_take}} & snap_data_q;
      clr_ovf   = {WIDTH{ack_take}} & snap_ovf_q;
   end

   // Flag and overflow update: set wins over clear; a repeat event on a set,
   // uncleared flag records an overflow.
   always_comb begin
      flags_d = bus.ev | (flags_q & ~clr_flags);
      ovf_d   = (bus.ev & flags_q & ~clr_flags) | (ovf_q & ~clr_ovf);
   end

   // Read FSM next state and snapshot capture.
   always_comb begin
      state_d     = state_q;
      snap_data_d = snap_data_q;
      snap_ovf_d  = snap_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.rd_req) begin
               snap_data_d = flags_q;
               snap_ovf_d  = ovf_q;
               state_d     = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (bus.rd_ack) begin
               state_d = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset aborts any read in progress without clearing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         flags_q     <= POR_VALUE[WIDTH-1:0];
         ovf_q       <= '0;
         snap_data_q <= '0;
         snap_ovf_q  <= '0;
      end else begin
         state_q     <= state_d;
         flags_q     <= flags_d;
         ovf_q       <= ovf_d;
         snap_data_q <= snap_data_d;
         snap_ovf_q  <= snap_ovf_d;
      end
   end

   // Outputs: irq follows the live flags, the read port shows the snapshot.
   always_comb begin
      bus.irq      = |flags_q;
      bus.rd_valid = (state_q == ST_PRESENT);
      bus.rd_data  = snap_data_q;
      bus.rd_ovf   = snap_ovf_q;
      dbg_state_o  = state_q;
   end

endmodule

// File: tb/tb_event_flag_reader.sv
// Bench for event_flag_reader: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the flag bank.
module tb_event_flag_reader;

   localparam int W = 8;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   event_flag_reader_if #(.WIDTH(W)) bus ();

   event_flag_reader #(
      .WIDTH     (W),
      .POR_VALUE (32'h81)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: live flags, overflow bits, a snapshot and the reader mode.
   bit       m_flag [W];
   bit       m_ovf  [W];
   bit       m_snap [W];
   bit       m_snov [W];
   int       m_mode;          // 0 waiting for request, 1 presenting, 2 cooling down
   int       ev_total [W];    // events issued per bit
   int       ev_seen  [W];    // events accounted for by snapshots or overflow

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input bit a [W]);
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = a[i];
      return v;
   endfunction

   function automatic bit any_set(input bit a [W]);
      for (int i = 0; i < W; i++) if (a[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < W; i++) begin
         m_flag[i] = (8'h81 >> i) & 1;
         m_ovf[i]  = 0;
         m_snap[i] = 0;
         m_snov[i] = 0;
      end
      m_mode = 0;
   endtask

   // Advance the model by one clock using the inputs presented this cycle.
   task automatic model_step(input logic [W-1:0] ev, input bit req, input bit ack);
      bit acked;
      bit nf [W];
      bit no [W];
      acked = (m_mode == 1) && ack;
      for (int i = 0; i < W; i++) begin
         bit cleared;
         cleared = acked && m_snap[i];
         nf[i] = m_flag[i];
         no[i] = m_ovf[i];
         if (acked && m_snov[i]) no[i] = 0;
         if (cleared) nf[i] = 0;
         if (ev[i]) begin
            ev_total[i]++;
            if (m_flag[i] && !cleared) begin
               no[i] = 1;
               ev_seen[i]++;    // merged into an already pending flag
            end
            nf[i] = 1;
         end
      end
      if (m_mode == 0 && req) begin
         for (int i = 0; i < W; i++) begin
            m_snap[i] = m_flag[i];
            m_snov[i] = m_ovf[i];
         end
         m_mode = 1;
      end else if (m_mode == 1 && ack) begin
         for (int i = 0; i < W; i++) if (m_snap[i]) ev_seen[i]++;
         m_mode = 2;
      end else if (m_mode == 2) begin
         m_mode = 0;
      end
      m_flag = nf;
      m_ovf  = no;
   endtask

   task automatic compare_outputs(input string tag);
      check({tag, ".irq"},   {31'd0, bus.irq},      {31'd0, any_set(m_flag)});
      check({tag, ".valid"}, {31'd0, bus.rd_valid}, {31'd0, m_mode == 1});
      if (m_mode == 1) begin
         check({tag, ".data"}, {24'd0, bus.rd_data}, {24'd0, pack(m_snap)});
         check({tag, ".ovf"},  {24'd0, bus.rd_ovf},  {24'd0, pack(m_snov)});
      end
   endtask

   // Driver: present inputs after the falling edge, clock once, then sample at
   // the next falling edge.
   task automatic cycle(input logic [W-1:0] ev, input bit req, input bit ack);
      bus.ev     = ev;
      bus.rd_req = req;
      bus.rd_ack = ack;
      @(posedge clk);
      model_step(ev, req, ack);
      @(negedge clk);
      bus.ev     = '0;
      bus.rd_req = 1'b0;
      bus.rd_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [W-1:0] prev_data;
   bit           prev_valid;

   initial begin
      bus.ev     = '0;
      bus.rd_req = 1'b0;
      bus.rd_ack = 1'b0;
      rst        = 1'b0;
      for (int i = 0; i < W; i++) begin
         ev_total[i] = 0;
         ev_seen[i]  = 0;
      end
      @(negedge clk);

      // 1: reset value and reset during a presented snapshot.
      do_reset();
      check("rst.irq",   {31'd0, bus.irq},      32'd1);
      check("rst.valid", {31'd0, bus.rd_valid}, 32'd0);
      cycle('0, 1, 0);
      check("rst.read",  {24'd0, bus.rd_data},  32'h81);
      check("rst.valid1",{31'd0, bus.rd_valid}, 32'd1);
      rst = 1'b1;
      #2;
      model_reset();
      check("rst.abort", {31'd0, bus.rd_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle('0, 1, 0);
      check("rst.keep",  {24'd0, bus.rd_data},  32'h81);
      cycle('0, 0, 1);
      cycle('0, 0, 0);
      check("rst.clr",   {31'd0, bus.irq},      32'd0);

      // 2: single event, read and clear.
      cycle(8'h05, 0, 0);
      cycle('0, 1, 0);
      check("t2.valid", {31'd0, bus.rd_valid}, 32'd1);
      check("t2.data",  {24'd0, bus.rd_data},  32'h05);
      check("t2.ovf",   {24'd0, bus.rd_ovf},   32'h00);
      cycle('0, 0, 1);
      check("t2.irq",   {31'd0, bus.irq},      32'd0);
      check("t2.hold",  {31'd0, bus.rd_valid}, 32'd0);
      cycle('0, 1, 0);
      check("t2.hold2", {31'd0, bus.rd_valid}, 32'd0);

      // 3: event arriving during presentation survives the acknowledge.
      cycle(8'h01, 0, 0);
      cycle('0, 1, 0);
      check("t3.data1", {24'd0, bus.rd_data}, 32'h01);
      cycle(8'h02, 0, 0);
      cycle('0, 0, 1);
      check("t3.irq",   {31'd0, bus.irq},     32'd1);
      cycle('0, 0, 0);
      cycle('0, 1, 0);
      check("t3.data2", {24'd0, bus.rd_data}, 32'h02);
      cycle('0, 0, 1);
      cycle('0, 0, 0);

      // 4: set wins over clear without overflow; repeat event overflows.
      cycle(8'h01, 0, 0);
      cycle('0, 1, 0);
      cycle(8'h01, 0, 1);
      check("t4.irq",   {31'd0, bus.irq}, 32'd1);
      cycle('0, 0, 0);
      cycle(8'h01, 0, 0);
      cycle('0, 1, 0);
      check("t4.data",  {24'd0, bus.rd_data}, 32'h01);
      check("t4.ovf",   {24'd0, bus.rd_ovf},  32'h01);
      cycle('0, 0, 1);
      cycle('0, 0, 0);
      cycle('0, 1, 0);
      check("t4.data0", {24'd0, bus.rd_data}, 32'h00);
      check("t4.ovf0",  {24'd0, bus.rd_ovf},  32'h00);
      cycle('0, 0, 1);
      cycle('0, 0, 0);

      // 5: ack while idle is ignored; held request gives one read per 3 cycles.
      cycle(8'h10, 0, 1);
      cycle('0, 0, 1);
      check("t5.idleack", {31'd0, bus.irq}, 32'd1);
      for (int k = 0; k < 9; k++) begin
         cycle('0, 1, 1);
         check("t5.pattern", {31'd0, bus.rd_valid}, {31'd0, (k % 3) == 0});
      end
      check("t5.irq", {31'd0, bus.irq}, 32'd0);
      cycle('0, 0, 0);
      cycle('0, 0, 0);

      // 6: random traffic against the model.
      for (int i = 0; i < W; i++) begin
         ev_total[i] = 0;
         ev_seen[i]  = 0;
         m_flag[i]   = 0;   // flags are all clear here; count from a clean slate
      end
      prev_valid = 0;
      prev_data  = '0;
      for (int n = 0; n < 10000; n++) begin
         logic [W-1:0] ev;
         ev = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         cycle(ev, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
         compare_outputs("rnd");
         if (prev_valid && bus.rd_valid)
            check("rnd.stable", {24'd0, bus.rd_data}, {24'd0, prev_data});
         prev_valid = bus.rd_valid;
         prev_data  = bus.rd_data;
      end
      // Drain: read until nothing is pending so every event is accounted for.
      for (int d = 0; d < 4; d++) begin
         while (m_mode != 0) cycle('0, 0, 1);
         cycle('0, 1, 0);
         cycle('0, 0, 1);
      end
      while (m_mode != 0) cycle('0, 0, 1);
      check("drain.irq", {31'd0, bus.irq}, 32'd0);
      for (int i = 0; i < W; i++)
         check("conserve", ev_seen[i], ev_total[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
